// File: rtl/count_enable_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : count_enable_ctrl                                            |
// | Description : Command-driven burst sequencer for the counter enable:       |
// |               issues cmd_len enables spaced cmd_div+1 running cycles,      |
// |               with pause/abort and a done pulse. CMD_QUEUE_EN adds a       |
// |               one-entry pending command for back-to-back bursts.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module count_enable_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_len,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             pause,
  input  logic             abort,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] pulses_left
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             enable_q;
  logic             done_q;
  logic [WIDTH-1:0] left_q;
  logic [DIV_W-1:0] pc_q;
  logic [DIV_W-1:0] div_q;

  logic             hs;
  logic             launch_d;
  logic [WIDTH-1:0] launch_len_d;
  logic [DIV_W-1:0] launch_div_d;

`ifdef CMD_QUEUE_EN
  logic             pend_valid_q;
  logic [WIDTH-1:0] pend_len_q;
  logic [DIV_W-1:0] pend_div_q;

  assign cmd_ready = !pend_valid_q;
`else
  assign cmd_ready = (state_q == S_IDLE);
`endif

  assign hs          = cmd_valid && cmd_ready;
  assign busy        = (state_q != S_IDLE);
  assign enable      = enable_q;
  assign done        = done_q;
  assign pulses_left = left_q;

  // A burst starts from IDLE on handshake, or straight out of DONE when chaining.
  always_comb begin
    launch_d     = 1'b0;
    launch_len_d = cmd_len;
    launch_div_d = cmd_div;
    case (state_q)
      S_IDLE: launch_d = hs;
      S_DONE: begin
`ifdef CMD_QUEUE_EN
        if (pend_valid_q) begin
          launch_d     = 1'b1;
          launch_len_d = pend_len_q;
          launch_div_d = pend_div_q;
        end else begin
          launch_d = hs;
        end
`else
        launch_d = 1'b0;
`endif
      end
      default: launch_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      left_q   <= '0;
      pc_q     <= '0;
      div_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          enable_q <= 1'b0;
          if (launch_d) begin
            state_q <= (launch_len_d == '0) ? S_DONE : S_RUN;
            left_q  <= launch_len_d;
            pc_q    <= launch_div_d;
            div_q   <= launch_div_d;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q  <= S_IDLE;
            enable_q <= 1'b0;
            left_q   <= '0;
          end else if (pause) begin
            enable_q <= 1'b0;
          end else if (pc_q == '0) begin
            enable_q <= 1'b1;
            pc_q     <= div_q;
            left_q   <= left_q - WIDTH'(1);
            if (left_q == WIDTH'(1)) begin
              state_q <= S_DONE;
            end
          end else begin
            enable_q <= 1'b0;
            pc_q     <= pc_q - DIV_W'(1);
          end
        end
        S_DONE: begin
          enable_q <= 1'b0;
          done_q   <= 1'b1;
          if (launch_d) begin
            state_q <= (launch_len_d == '0) ? S_DONE : S_RUN;
            left_q  <= launch_len_d;
            pc_q    <= launch_div_d;
            div_q   <= launch_div_d;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CMD_QUEUE_EN
  // Only a command accepted mid-burst is parked; IDLE/DONE handshakes launch directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_len_q   <= '0;
      pend_div_q   <= '0;
    end else if (state_q == S_RUN && abort) begin
      pend_valid_q <= 1'b0;
    end else if (state_q == S_DONE && pend_valid_q) begin
      pend_valid_q <= 1'b0;
    end else if (hs && state_q == S_RUN) begin
      pend_valid_q <= 1'b1;
      pend_len_q   <= cmd_len;
      pend_div_q   <= cmd_div;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_count_enable_ctrl.sv
`default_nettype none
// Self-checking bench for count_enable_ctrl: vector table, hand-written burst
// sequences and a randomized run against a burst-level reference model.
module tb_count_enable_ctrl;

`ifdef CMD_QUEUE_EN
  localparam bit QM = 1'b1;
`else
  localparam bit QM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_len = 8'd0;
  logic [3:0] cmd_div = 4'd0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       cmd_ready, enable, busy, done;
  logic [7:0] pulses_left;

  count_enable_ctrl #(.WIDTH(8), .DIV_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .cmd_div     (cmd_div),
    .pause       (pause),
    .abort       (abort),
    .enable      (enable),
    .busy        (busy),
    .done        (done),
    .pulses_left (pulses_left)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({enable, done, busy, cmd_ready, pulses_left});
  endfunction

  // Burst-level model: counts running edges of the current burst; a pulse is due
  // on every (div+1)-th running edge until len pulses have been issued.
  typedef struct {int len; int dv;} cmd_t;
  int   m_phase;  // 0 idle, 1 bursting, 2 finishing
  int   m_len, m_div, m_issued, m_runs;
  bit   m_en, m_done;
  cmd_t m_pend[$];

  function automatic bit m_ready();
    return QM ? (m_pend.size() == 0) : (m_phase == 0);
  endfunction

  task automatic m_start(input int len, input int dv);
    m_len = len; m_div = dv; m_issued = 0; m_runs = 0;
    m_phase = (len == 0) ? 2 : 1;
  endtask

  task automatic m_reset();
    m_phase = 0; m_len = 0; m_div = 0; m_issued = 0; m_runs = 0;
    m_en = 1'b0; m_done = 1'b0; m_pend.delete();
  endtask

  task automatic m_step();
    bit   hs;
    cmd_t c;
    hs = cmd_valid && m_ready();
    m_en = 1'b0; m_done = 1'b0;
    case (m_phase)
      0: if (hs) m_start(int'(cmd_len), int'(cmd_div));
      1: begin
        if (abort) begin
          m_phase = 0; m_len = 0; m_issued = 0; m_pend.delete();
        end else begin
          if (QM && hs) begin
            c.len = int'(cmd_len); c.dv = int'(cmd_div);
            m_pend.push_back(c);
          end
          if (!pause) begin
            m_runs++;
            if (m_runs % (m_div + 1) == 0) begin
              m_en = 1'b1; m_issued++;
              if (m_issued == m_len) m_phase = 2;
            end
          end
        end
      end
      default: begin
        m_done = 1'b1;
        if (m_pend.size() > 0) begin
          c = m_pend.pop_front();
          m_start(c.len, c.dv);
        end else if (hs) begin
          m_start(int'(cmd_len), int'(cmd_div));
        end else begin
          m_phase = 0;
        end
      end
    endcase
  endtask

  function automatic logic [31:0] m_outs();
    return 32'({m_en, m_done, (m_phase != 0), m_ready(), 8'(m_len - m_issued)});
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic clear_inputs();
    cmd_valid = 1'b0; cmd_len = 8'd0; cmd_div = 4'd0; pause = 1'b0; abort = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Runs n edges; the command is presented before edge 0 only. Bit e of each mask
  // holds the output observed after edge e.
  task automatic run_mask(input int n, input int plo, input int phi, input int abort_at,
                          output logic [31:0] en_m, output logic [31:0] dn_m,
                          output logic [31:0] bz_m);
    en_m = '0; dn_m = '0; bz_m = '0;
    for (int e = 0; e < n; e++) begin
      cmd_valid = (e == 0);
      pause     = (e >= plo && e <= phi);
      abort     = (e == abort_at);
      tick();
      en_m[e] = enable; dn_m[e] = done; bz_m[e] = busy;
    end
    clear_inputs();
  endtask

  typedef struct packed {
    logic v; logic [7:0] len; logic [3:0] dv; logic p; logic a;
    logic en; logic dn; logic bz; logic rdy; logic [7:0] left;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] en_m, dn_m, bz_m;
  int          cnt, done_at;

  initial begin
    tbl[0] = '{1'b1, 8'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, QM,   8'd3};
    tbl[1] = '{1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, QM,   8'd2};
    tbl[2] = '{1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, QM,   8'd1};
    tbl[3] = '{1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, QM,   8'd0};
    tbl[4] = '{1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[5] = '{1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[6] = '{1'b1, 8'd0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, QM,   8'd0};
    tbl[7] = '{1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[8] = '{1'b0, 8'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[9] = '{1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};

    // Reset state
    m_reset();
    @(posedge clk);
    #1;
    check("reset_state", outs(), 32'({1'b0, 1'b0, 1'b0, 1'b1, 8'd0}));
    rst = 1'b0;

    // Vector table: len=3 div=0 burst, len=0 command, pause/abort ignored in IDLE
    for (int i = 0; i < 10; i++) begin
      cmd_valid = tbl[i].v; cmd_len = tbl[i].len; cmd_div = tbl[i].dv;
      pause = tbl[i].p; abort = tbl[i].a;
      tick();
      check($sformatf("tbl[%0d]", i), outs(),
            32'({tbl[i].en, tbl[i].dn, tbl[i].bz, tbl[i].rdy, tbl[i].left}));
    end
    clear_inputs();

    // len=4 div=2: enables after E3,E6,E9,E12; done after E13
    do_reset();
    cmd_len = 8'd4; cmd_div = 4'd2;
    run_mask(20, -1, -1, -1, en_m, dn_m, bz_m);
    check("div2_enables", en_m, 32'h0000_1248);
    check("div2_done", dn_m, 32'h0000_2000);

    // len=5 div=0, pause over E3..E5: pulses 3..5 and done slip by 3 edges
    do_reset();
    cmd_len = 8'd5; cmd_div = 4'd0;
    run_mask(16, 3, 5, -1, en_m, dn_m, bz_m);
    check("pause_enables", en_m, 32'h0000_01C6);
    check("pause_done", dn_m, 32'h0000_0200);

    // len=10 div=1, abort before E7 (after the 3rd enable at E6)
    do_reset();
    cmd_len = 8'd10; cmd_div = 4'd1;
    run_mask(14, -1, -1, 7, en_m, dn_m, bz_m);
    check("abort_enables", en_m, 32'h0000_0054);
    check("abort_no_done", dn_m, 32'h0000_0000);
    check("abort_busy", bz_m, 32'h0000_007F);
    check("abort_idle_outs", outs(), 32'({1'b0, 1'b0, 1'b0, 1'b1, 8'd0}));

    // Async reset mid-burst clears outputs without a clock edge
    do_reset();
    cmd_len = 8'd10; cmd_div = 4'd0;
    run_mask(3, -1, -1, -1, en_m, dn_m, bz_m);
    check("pre_rst_enable", 32'(enable), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outs", outs(), 32'({1'b0, 1'b0, 1'b0, 1'b1, 8'd0}));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Maximum length: 255 enables, done one edge after the last
    do_reset();
    cmd_valid = 1'b1; cmd_len = 8'd255; cmd_div = 4'd0;
    tick();
    cmd_valid = 1'b0;
    check("max_len_left", 32'(pulses_left), 32'd255);
    cnt = 0; done_at = -1;
    for (int e = 1; e < 300; e++) begin
      tick();
      if (enable) cnt++;
      if (done && done_at < 0) done_at = e;
    end
    check("max_len_count", 32'(cnt), 32'd255);
    check("max_len_done", 32'(done_at), 32'd256);

`ifdef CMD_QUEUE_EN
    // Chained bursts: A len=2 at E0, B len=3 parked at E1
    do_reset();
    en_m = '0; dn_m = '0; bz_m = '0;
    for (int e = 0; e < 12; e++) begin
      cmd_valid = (e <= 1);
      cmd_len   = (e == 0) ? 8'd2 : 8'd3;
      cmd_div   = 4'd0;
      tick();
      en_m[e] = enable; dn_m[e] = done; bz_m[e] = busy;
      if (e == 1) check("queue_full_ready", 32'(cmd_ready), 32'd0);
    end
    clear_inputs();
    check("queue_enables", en_m, 32'h0000_0076);
    check("queue_dones", dn_m, 32'h0000_0088);
    check("queue_busy", bz_m, 32'h0000_007F);
`endif

    // Randomized run against the burst-level model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 9) < 3);
      cmd_len   = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40))
                                               : 8'($urandom_range(0, 6));
      cmd_div   = 4'($urandom_range(0, 3));
      pause     = ($urandom_range(0, 99) < 15);
      abort     = ($urandom_range(0, 99) < 3);
      tick();
      check("random", outs(), m_outs());
    end
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
